// File: rtl/serial_addsub_unit.sv
// Bit-serial add/subtract unit: computes one result bit per clock, LSB first, after a synchronised button press.
// Result is {carry/borrow-out, WIDTH-bit sum/difference}; flags and Result only change when an operation completes.
module serial_addsub_unit #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Mode,
  input  logic             Bin,
  input  logic [WIDTH-1:0] OpX,
  input  logic [WIDTH-1:0] OpY,
  output logic [WIDTH:0]   Result,
  output logic             Overflow,
  output logic             Zero,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       DbgState
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic             r_sync_d;
  logic             w_start_edge;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [CW-1:0]    r_cnt;
  logic             r_mode;
  logic             r_c;
  logic             r_sx;
  logic             r_sy;
  logic             w_a;
  logic             w_b;
  logic             w_s;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_diff;
  logic             w_ovf;

  // Button synchroniser and rising-edge detector on its output.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], Start};
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_start_edge = r_sync[SYNC_STAGES-1] & ~r_sync_d;

  // One full-adder / full-subtractor slice; r_c is the carry or borrow chain.
  assign w_a    = r_a[0];
  assign w_b    = r_b[0];
  assign w_s    = w_a ^ w_b ^ r_c;
  assign w_cout = r_mode ? ((w_a & w_b) | (r_c & (w_a ^ w_b)))
                         : ((~w_a & w_b) | (~(w_a ^ w_b) & r_c));
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_diff = {w_s, r_work[WIDTH-1:1]};
  assign w_ovf  = r_mode ? ((r_sx == r_sy) && (w_s != r_sx))
                         : ((r_sx != r_sy) && (w_s != r_sx));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_edge) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Busy     = (r_state == S_SHIFT);
    Done     = (r_state == S_DONE);
    DbgState = r_state;
  end

  // Working registers; Result and flags load only on the final bit so no partial value is ever visible.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_cnt    <= '0;
      r_mode   <= 1'b0;
      r_c      <= 1'b0;
      r_sx     <= 1'b0;
      r_sy     <= 1'b0;
      Result   <= '0;
      Overflow <= 1'b0;
      Zero     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_a    <= OpX;
            r_b    <= OpY;
            r_mode <= Mode;
            r_c    <= Bin;
            r_cnt  <= '0;
            r_sx   <= OpX[WIDTH-1];
            r_sy   <= OpY[WIDTH-1];
          end
        end
        S_SHIFT: begin
          r_a    <= {1'b0, r_a[WIDTH-1:1]};
          r_b    <= {1'b0, r_b[WIDTH-1:1]};
          r_work <= w_diff;
          r_c    <= w_cout;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            Result   <= {w_cout, w_diff};
            Overflow <= w_ovf;
            Zero     <= (w_diff == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Bench for serial_addsub_unit: a 4-bit/2-stage and an 8-bit/3-stage instance share the stimulus,
// each operation is checked cycle by cycle for Busy/Done timing and against an arithmetic model.
module tb_serial_addsub_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       bin = 1'b0;
  logic [7:0] opx = '0;
  logic [7:0] opy = '0;

  logic [4:0] res4;
  logic       ovf4, zero4, busy4, done4;
  logic [1:0] dbg4;
  logic [8:0] res8;
  logic       ovf8, zero8, busy8, done8;
  logic [1:0] dbg8;

  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  serial_addsub_unit #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .Clk(clk), .Rst_n(rst_n), .Start(start), .Mode(mode), .Bin(bin),
    .OpX(opx[3:0]), .OpY(opy[3:0]), .Result(res4), .Overflow(ovf4),
    .Zero(zero4), .Busy(busy4), .Done(done4), .DbgState(dbg4)
  );

  serial_addsub_unit #(.WIDTH(8), .SYNC_STAGES(3)) dut8 (
    .Clk(clk), .Rst_n(rst_n), .Start(start), .Mode(mode), .Bin(bin),
    .OpX(opx), .OpY(opy), .Result(res8), .Overflow(ovf8),
    .Zero(zero8), .Busy(busy8), .Done(done8), .DbgState(dbg8)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Packed expectation: {overflow, zero, result[8:0]} from plain integer arithmetic.
  function automatic logic [10:0] model(input int w, input int x, input int y, input int m, input int b);
    int half, full, r, sx, sy, sr;
    logic [10:0] o;
    half = 1 << (w - 1);
    full = 1 << w;
    x = x & (full - 1);
    y = y & (full - 1);
    r  = (m != 0) ? (x + y + b) : (x - y - b);
    r  = r & ((full << 1) - 1);
    sx = (x >= half) ? x - full : x;
    sy = (y >= half) ? y - full : y;
    sr = (m != 0) ? (sx + sy + b) : (sx - sy - b);
    o = '0;
    o[8:0] = 9'(r);
    o[9]   = ((r & (full - 1)) == 0);
    o[10]  = (sr > half - 1) || (sr < -half);
    return o;
  endfunction

  // One press on the selected instance, observed for a fixed 30-cycle window starting at edge k.
  task automatic do_op(input bit sel, input int x, input int y, input bit m, input bit b,
                       input int hold, input int repress, input bit use_exp, input logic [10:0] exp_in);
    int w, s, dones;
    logic [10:0] e;
    logic [10:0] got;
    logic busy_o, done_o;
    w = sel ? 8 : 4;
    s = sel ? 3 : 2;
    dones = 0;
    e = use_exp ? exp_in : model(w, x, y, int'(m), int'(b));
    exp_q.push_back(e);
    @(negedge clk);
    opx = 8'(x); opy = 8'(y); mode = m; bin = b; start = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(posedge clk);
      #1;
      busy_o = sel ? busy8 : busy4;
      done_o = sel ? done8 : done4;
      check_eq(sel ? "busy8" : "busy4", 32'(busy_o), 32'(j >= s && j < s + w));
      check_eq(sel ? "done8" : "done4", 32'(done_o), 32'(j == s + w));
      if (done_o) begin
        dones++;
        got = sel ? {ovf8, zero8, res8} : {ovf4, zero4, 4'b0, res4};
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("result",   32'(got[8:0]), 32'(e[8:0]));
          check_eq("zero",     32'(got[9]),   32'(e[9]));
          check_eq("overflow", 32'(got[10]),  32'(e[10]));
        end
      end
      start = ((j + 1) < hold) || ((j + 1) == repress);
      if (j >= s) begin
        opx  = 8'($urandom_range(0, 255));
        opy  = 8'($urandom_range(0, 255));
        mode = 1'($urandom_range(0, 1));
        bin  = 1'($urandom_range(0, 1));
      end
    end
    check_eq("done_count", 32'(dones), 32'd1);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_result4", 32'(res4), 32'd0);
    check_eq("rst_flags4", 32'({ovf4, zero4, busy4, done4}), 32'd0);
    check_eq("rst_state4", 32'(dbg4), 32'd0);
    check_eq("rst_result8", 32'(res8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    do_op(1'b0, 5, 3, 1'b0, 1'b0, 1, 0, 1'b1, {1'b0, 1'b0, 9'h002});
    do_op(1'b0, 3, 5, 1'b0, 1'b1, 1, 0, 1'b1, {1'b0, 1'b0, 9'h01D});
    do_op(1'b0, 8, 1, 1'b0, 1'b0, 1, 0, 1'b1, {1'b1, 1'b0, 9'h007});
    do_op(1'b0, 7, 1, 1'b1, 1'b0, 1, 0, 1'b1, {1'b1, 1'b0, 9'h008});
    do_op(1'b0, 15, 1, 1'b1, 1'b0, 1, 0, 1'b1, {1'b0, 1'b1, 9'h010});
    do_op(1'b0, 0, 1, 1'b0, 1'b0, 1, 0, 1'b1, {1'b0, 1'b0, 9'h01F});
    do_op(1'b1, 8'h80, 8'h01, 1'b0, 1'b0, 1, 0, 1'b1, {1'b1, 1'b0, 9'h07F});

    // Held button, then a re-press that lands while the unit is busy.
    do_op(1'b0, 6, 9, 1'b1, 1'b1, 20, 0, 1'b0, '0);
    do_op(1'b0, 12, 4, 1'b0, 1'b1, 1, 3, 1'b0, '0);

    // Reset in the middle of a subtraction.
    @(negedge clk);
    opx = 8'd5; opy = 8'd3; mode = 1'b0; bin = 1'b0; start = 1'b1;
    for (int j = 0; j <= 4; j++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check_eq("mid_busy4", 32'(busy4), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_result4", 32'(res4), 32'd0);
    check_eq("abort_flags4", 32'({ovf4, zero4, busy4, done4}), 32'd0);
    check_eq("abort_state4", 32'(dbg4), 32'd0);
    check_eq("abort_result8", 32'(res8), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    do_op(1'b0, 5, 3, 1'b0, 1'b0, 1, 0, 1'b1, {1'b0, 1'b0, 9'h002});

    for (int i = 0; i < 20; i++) begin
      do_op(1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0, 1'b0, '0);
    end
    for (int i = 0; i < 12; i++) begin
      do_op(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0, 1'b0, '0);
    end
    do_op(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 1, 0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub_unit.md
Name: serial_addsub_unit

Overview:
Parametrised bit-serial add/subtract unit; the sequential successor to the 4-bit combinational switch subtractor. A synchronised button press latches two WIDTH-bit operands, a mode bit and a carry/borrow-in. The unit computes one bit per clock, LSB first, then presents a registered (WIDTH+1)-bit result plus flags. Result format matches the existing display data: {carry/borrow-out, WIDTH-bit sum/difference}, so it can drive the existing display path.

Parameters:
WIDTH, 4, operand width in bits (>=2)
SYNC_STAGES, 2, flip-flop stages synchronising the raw Start button (>=2)

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Start  input  1  raw push-button; one operation per synchronised 0->1 edge
Mode  input  1  0 = subtract (OpX-OpY-Bin), 1 = add (OpX+OpY+Bin)
Bin  input  1  borrow-in (subtract) / carry-in (add)
OpX  input  WIDTH  operand X (switches)
OpY  input  WIDTH  operand Y (switches)
Result  output  WIDTH+1  [WIDTH] = carry/borrow-out, [WIDTH-1:0] = sum/difference
Overflow  output  1  two's-complement overflow of the last operation
Zero  output  1  Result[WIDTH-1:0] == 0 for the last operation
Busy  output  1  high while bits are being computed
Done  output  1  one-cycle pulse when Result/flags update

Behaviour:
- Reset: asynchronous, active-low. Sync chain, edge-detect flop, state = IDLE, working registers, Result = 0, Overflow = 0, Zero = 0, Busy = 0, Done = 0. Assertion mid-operation aborts it; no partial result survives.
- Start passes through SYNC_STAGES flops. StartEdge = sync_out & ~sync_out_d, a one-cycle pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on StartEdge, latch OpX/OpY into shift registers A/B, latch Mode, chain bit c = Bin, bit counter = 0, record sign bits X[WIDTH-1] and Y[WIDTH-1], then go to SHIFT.
- SHIFT: each cycle uses a = A[0], b = B[0].
  - Add: s = a^b^c; c' = (a&b)|(c&(a^b)).
  - Sub: s = a^b^c; c' = (~a&b)|(~(a^b)&c).
  - Shift s into the MSB of a working register (right shift). Shift A and B right. Increment the counter.
  - After the WIDTH-th bit, go to DONE. On that same edge load Result = {c', working}, Overflow and Zero.
- DONE: Done = 1 for exactly this one cycle, then go to IDLE unconditionally.
- Busy = (state == SHIFT).
- Overflow:
  - Add: sign X == sign Y and result MSB != sign X.
  - Sub: sign X != sign Y and result MSB != sign X.
- Latency: let k be the first edge at which Start is sampled high.
  - Enter SHIFT at edge k+SYNC_STAGES.
  - Result, flags and Done update at edge k+SYNC_STAGES+WIDTH.
  - Back to IDLE at edge k+SYNC_STAGES+WIDTH+1.
- Start edges arriving in SHIFT or DONE are dropped, not queued. Holding Start high produces exactly one operation; a new operation needs a release and a re-press.
- OpX, OpY, Mode and Bin may change freely after the IDLE latch edge without affecting the operation in flight.
- Result, Overflow and Zero hold their last value between operations. They never show partial values.
- Unsigned wrap: 0 - 1 gives all-ones difference with borrow-out 1. Max + 1 gives 0 with carry-out 1 and Zero = 1.

Test Plan:
- WIDTH=4, Mode=0, OpX=5, OpY=3, Bin=0, press at edge k -> Busy high at k+2..k+5. At k+6: Result=5'b0_0010, Overflow=0, Zero=0, Done high for one cycle.
- WIDTH=4, Mode=0, OpX=3, OpY=5, Bin=1 -> Result=5'b1_1101, Overflow=0. Then Mode=0, OpX=8, OpY=1 -> Result=5'b0_0111, Overflow=1.
- WIDTH=4, Mode=1: OpX=7, OpY=1 -> 5'b0_1000, Overflow=1. OpX=15, OpY=1 -> 5'b1_0000, Zero=1, Overflow=0.
- Start held high 20 cycles, plus a second press during Busy -> exactly one Done pulse. Operand changes during SHIFT do not alter Result.
- Rst_n pulsed low during SHIFT bit 2 -> all outputs 0 immediately, state IDLE. A following press of 5-3 completes normally with latency SYNC_STAGES+WIDTH.
- WIDTH=8, SYNC_STAGES=3, Mode=0, OpX=8'h80, OpY=8'h01 -> Result=9'h07F, Overflow=1, Done at edge k+11.
